// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a byte-lane on-chip RAM: one read or write burst at a time,
// FIXED/INCR/WRAP bursts of 1-16 beats, byte strobes, per-beat SLVERR/DECERR responses.
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_AW    = 14
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [3:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic [1:0]  s_axi_arlock,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [3:0]  s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [3:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic [1:0]  s_axi_awlock,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [3:0]  s_axi_wid,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int         DEPTH       = 1 << MEM_AW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  id_reg;
  logic [31:0] addr_reg;
  logic [3:0]  len_reg;
  logic [3:0]  beat_reg;
  logic [2:0]  size_reg;
  logic [1:0]  burst_reg;
  logic [1:0]  rresp_reg;
  logic [1:0]  bresp_reg;
  logic        prefer_rd_reg;

  logic        ar_hs, aw_hs, r_hs, w_hs, last_beat;
  logic [31:0] next_addr_w;
  logic [1:0]  cur_resp;
  logic [1:0]  bresp_next;
  logic        rd_en, wr_en;
  logic [MEM_AW-1:0] rd_idx, wr_idx;
  logic [31:0] mem_q;

  function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [2:0] sz,
                                           input logic [1:0] bt);
    logic [31:0] off;
    off = a - BASE_ADDR;
    if (sz > 3'd2 || bt == 2'b11)
      return RESP_SLVERR;
    else if ({1'b0, off} >= (33'd4 << MEM_AW))
      return RESP_DECERR;
    else
      return RESP_OKAY;
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[MEM_AW+1:2];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] ln,
                                            input logic [2:0] sz, input logic [1:0] bt);
    logic [31:0] step, mask;
    step = 32'd1 << sz;
    mask = ((32'(ln) + 32'd1) << sz) - 32'd1;
    case (bt)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

  // Round-robin between AR and AW when both are pending in IDLE
  assign s_axi_arready = aresetn & (state_reg == IDLE) & s_axi_arvalid
                         & (~s_axi_awvalid | prefer_rd_reg);
  assign s_axi_awready = aresetn & (state_reg == IDLE) & s_axi_awvalid
                         & (~s_axi_arvalid | ~prefer_rd_reg);

  assign ar_hs       = s_axi_arvalid & s_axi_arready;
  assign aw_hs       = s_axi_awvalid & s_axi_awready;
  assign r_hs        = s_axi_rvalid & s_axi_rready;
  assign w_hs        = s_axi_wvalid & s_axi_wready;
  assign last_beat   = (beat_reg == len_reg);
  assign next_addr_w = next_addr(addr_reg, len_reg, size_reg, burst_reg);
  assign cur_resp    = beat_resp(addr_reg, size_reg, burst_reg);

  always_comb begin
    bresp_next = bresp_reg;
    if (cur_resp == RESP_SLVERR || (s_axi_wlast != last_beat))
      bresp_next = RESP_SLVERR;
    else if (cur_resp == RESP_DECERR && bresp_reg != RESP_SLVERR)
      bresp_next = RESP_DECERR;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ar_hs)
          state_next = RDATA;
        else if (aw_hs)
          state_next = WDATA;
      end
      RDATA: if (r_hs && last_beat) state_next = IDLE;
      WDATA: if (w_hs && last_beat) state_next = WRESP;
      WRESP: if (s_axi_bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_reg        <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      beat_reg      <= '0;
      size_reg      <= '0;
      burst_reg     <= '0;
      rresp_reg     <= RESP_OKAY;
      bresp_reg     <= RESP_OKAY;
      prefer_rd_reg <= 1'b1;
    end else begin
      if (ar_hs || aw_hs)
        prefer_rd_reg <= ~prefer_rd_reg;
      if (ar_hs) begin
        id_reg    <= s_axi_arid;
        addr_reg  <= s_axi_araddr;
        len_reg   <= s_axi_arlen;
        size_reg  <= s_axi_arsize;
        burst_reg <= s_axi_arburst;
        beat_reg  <= '0;
        rresp_reg <= beat_resp(s_axi_araddr, s_axi_arsize, s_axi_arburst);
      end else if (aw_hs) begin
        id_reg    <= s_axi_awid;
        addr_reg  <= s_axi_awaddr;
        len_reg   <= s_axi_awlen;
        size_reg  <= s_axi_awsize;
        burst_reg <= s_axi_awburst;
        beat_reg  <= '0;
        bresp_reg <= RESP_OKAY;
      end else if (r_hs && !last_beat) begin
        addr_reg  <= next_addr_w;
        beat_reg  <= beat_reg + 4'd1;
        rresp_reg <= beat_resp(next_addr_w, size_reg, burst_reg);
      end else if (w_hs) begin
        addr_reg  <= next_addr_w;
        beat_reg  <= beat_reg + 4'd1;
        bresp_reg <= bresp_next;
      end
    end
  end

  // The RAM read is issued one edge ahead so each beat's word is ready when rvalid shows it
  assign rd_en  = ar_hs | (r_hs & ~last_beat);
  assign rd_idx = word_idx(ar_hs ? s_axi_araddr : next_addr_w);
  assign wr_en  = w_hs & (cur_resp == RESP_OKAY);
  assign wr_idx = word_idx(addr_reg);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;
      always_ff @(posedge aclk) begin
        if (wr_en && s_axi_wstrb[gi])
          lane_mem[wr_idx] <= s_axi_wdata[gi*8 +: 8];
        if (rd_en)
          lane_q_reg <= lane_mem[rd_idx];
      end
      assign mem_q[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

  assign s_axi_rvalid = (state_reg == RDATA);
  assign s_axi_rdata  = (s_axi_rvalid && rresp_reg == RESP_OKAY) ? mem_q : 32'd0;
  assign s_axi_rid    = id_reg;
  assign s_axi_rresp  = rresp_reg;
  assign s_axi_rlast  = s_axi_rvalid & last_beat;
  assign s_axi_wready = (state_reg == WDATA);
  assign s_axi_bvalid = (state_reg == WRESP);
  assign s_axi_bid    = id_reg;
  assign s_axi_bresp  = bresp_reg;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot,
                           s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: expected R/B responses are queued as stimulus is
// issued and compared against beats captured by the channel monitors.
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_axi_arid, s_axi_awid, s_axi_wid, s_axi_rid, s_axi_bid;
  logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_arlen, s_axi_awlen, s_axi_arcache, s_axi_awcache, s_axi_wstrb;
  logic [2:0]  s_axi_arsize, s_axi_awsize, s_axi_arprot, s_axi_awprot;
  logic [1:0]  s_axi_arburst, s_axi_awburst, s_axi_arlock, s_axi_awlock, s_axi_rresp, s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready, s_axi_awvalid, s_axi_awready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
  );

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    int          cyc;
  } rbeat_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bbeat_t;

  rbeat_t exp_r_q[$], got_r_q[$];
  bbeat_t exp_b_q[$], got_b_q[$];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (aresetn && s_axi_rvalid && s_axi_rready)
      got_r_q.push_back('{s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid, cyc});
    if (aresetn && s_axi_bvalid && s_axi_bready)
      got_b_q.push_back('{s_axi_bid, s_axi_bresp});
  end

  task automatic default_inputs();
    s_axi_arvalid = 0; s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_wlast = 0;
    s_axi_rready = 1; s_axi_bready = 1;
    s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
    s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_arlock = 0; s_axi_arcache = 0; s_axi_arprot = 0;
    s_axi_awlock = 0; s_axi_awcache = 0; s_axi_awprot = 0;
    s_axi_wid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
    int n = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1;
    @(negedge aclk);
    while (!s_axi_arready && n < 100) begin @(negedge aclk); n++; end
    hs_cyc = cyc;
    if (!s_axi_arready) begin
      checks++; failures++;
      $display("FAIL ar_handshake: arready=%0b required=1 within 100 cycles", s_axi_arready);
    end
    @(posedge aclk); #1;
    s_axi_arvalid = 0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1;
    @(negedge aclk);
    while (!s_axi_awready && n < 100) begin @(negedge aclk); n++; end
    if (!s_axi_awready) begin
      checks++; failures++;
      $display("FAIL aw_handshake: awready=%0b required=1 within 100 cycles", s_axi_awready);
    end
    @(posedge aclk); #1;
    s_axi_awvalid = 0;
  endtask

  task automatic send_w(input int len, input int early);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      s_axi_wdata = wbuf[i]; s_axi_wstrb = sbuf[i];
      s_axi_wlast = (i == len) || (i == early); s_axi_wvalid = 1;
      @(negedge aclk);
      while (!s_axi_wready && n < 100) begin @(negedge aclk); n++; end
      if (!s_axi_wready) begin
        checks++; failures++;
        $display("FAIL w_handshake beat%0d: wready=%0b required=1 within 100 cycles", i, s_axi_wready);
      end
      @(posedge aclk); #1;
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
  endtask

  task automatic wait_r(input int count);
    int n = 0;
    while (got_r_q.size() < count && n < 200) begin @(posedge aclk); n++; end
    if (got_r_q.size() < count) begin
      checks++; failures++;
      $display("FAIL r_timeout: beats=%0d required=%0d", got_r_q.size(), count);
    end
    #1;
  endtask

  task automatic wait_b();
    int n = 0;
    while (got_b_q.size() < 1 && n < 200) begin @(posedge aclk); n++; end
    if (got_b_q.size() < 1) begin
      checks++; failures++;
      $display("FAIL b_timeout: responses=0 required=1");
    end
    #1;
  endtask

  task automatic apply_reset();
    default_inputs();
    aresetn = 0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1;
    got_r_q.delete(); got_b_q.delete();
  endtask

  task automatic test_reset();
    default_inputs();
    aresetn = 0;
    s_axi_arvalid = 1; s_axi_awvalid = 1;
    @(negedge aclk);
    checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_handshakes: ar/aw/w/r/b=%b required=00000",
               {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid});
    end
    checks++;
    if ({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_bid, s_axi_bresp} !== 45'd0) begin
      failures++;
      $display("FAIL reset_outputs: rid=%h rdata=%h rresp=%b rlast=%b bid=%h bresp=%b required all 0",
               s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_bid, s_axi_bresp);
    end
    default_inputs();
    @(posedge aclk); #1 aresetn = 1;
    @(negedge aclk);
    checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid} !== 5'b0) begin
      failures++;
      $display("FAIL post_reset_idle: ar/aw/w/r/b=%b required=00000",
               {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid});
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_incr_write_read();
    int hs;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h11 * (i + 1); sbuf[i] = 4'hF; end
    exp_b_q.push_back('{4'd5, OKAY});
    send_aw(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
    send_w(3, -1);
    wait_b();
    while (exp_b_q.size() > 0) begin
      bbeat_t e, g;
      e = exp_b_q.pop_front();
      checks++;
      if (got_b_q.size() == 0) begin
        failures++; $display("FAIL incr_bresp: got none, required id=%0d resp=%b", e.id, e.resp);
      end else begin
        g = got_b_q.pop_front();
        if (g.id !== e.id || g.resp !== e.resp) begin
          failures++;
          $display("FAIL incr_bresp: got id=%0d resp=%b, required id=%0d resp=%b", g.id, g.resp, e.id, e.resp);
        end
      end
    end
    for (int i = 0; i < 4; i++) exp_r_q.push_back('{32'h11 * (i + 1), OKAY, i == 3, 4'd7, 0});
    send_ar(4'd7, 32'h100, 4'd3, 3'd2, 2'b01, hs);
    wait_r(4);
    for (int i = 0; exp_r_q.size() > 0; i++) begin
      rbeat_t e, g;
      e = exp_r_q.pop_front();
      checks++;
      if (got_r_q.size() == 0) begin
        failures++; $display("FAIL incr_read beat%0d: got none, required data=%h", i, e.data);
      end else begin
        g = got_r_q.pop_front();
        if (g.data !== e.data || g.resp !== e.resp || g.last !== e.last || g.id !== e.id
            || g.cyc != hs + 1 + i) begin
          failures++;
          $display("FAIL incr_read beat%0d: got data=%h resp=%b last=%b id=%0d cyc=%0d, required data=%h resp=%b last=%b id=%0d cyc=%0d",
                   i, g.data, g.resp, g.last, g.id, g.cyc, e.data, e.resp, e.last, e.id, hs + 1 + i);
        end
      end
    end
  endtask

  task automatic test_wrap_read();
    int hs;
    int order [4] = '{2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA000_0000 + 32'h0111_1111 * i; sbuf[i] = 4'hF; end
    send_aw(4'd1, 32'h0, 4'd3, 3'd2, 2'b01);
    send_w(3, -1);
    exp_b_q.push_back('{4'd1, OKAY});
    wait_b();
    for (int i = 0; i < 4; i++)
      exp_r_q.push_back('{32'hA000_0000 + 32'h0111_1111 * order[i], OKAY, i == 3, 4'd2, 0});
    send_ar(4'd2, 32'h8, 4'd3, 3'd2, 2'b10, hs);
    wait_r(4);
    while (exp_b_q.size() > 0) begin
      bbeat_t e, g;
      e = exp_b_q.pop_front();
      checks++;
      g = got_b_q.size() > 0 ? got_b_q.pop_front() : '{4'hx, 2'bxx};
      if (g.id !== e.id || g.resp !== e.resp) begin
        failures++;
        $display("FAIL wrap_preload_bresp: got id=%0d resp=%b, required id=%0d resp=%b", g.id, g.resp, e.id, e.resp);
      end
    end
    for (int i = 0; exp_r_q.size() > 0; i++) begin
      rbeat_t e, g;
      e = exp_r_q.pop_front();
      checks++;
      g = got_r_q.size() > 0 ? got_r_q.pop_front() : '{32'hx, 2'bxx, 1'bx, 4'hx, 0};
      if (g.data !== e.data || g.resp !== e.resp || g.last !== e.last || g.id !== e.id) begin
        failures++;
        $display("FAIL wrap_read beat%0d: got data=%h resp=%b last=%b id=%0d, required data=%h resp=%b last=%b id=%0d",
                 i, g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id);
      end
    end
  endtask

  task automatic test_strobe();
    int hs;
    wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'hF;
    send_aw(4'd3, 32'h200, 4'd0, 3'd2, 2'b01);
    send_w(0, -1);
    exp_b_q.push_back('{4'd3, OKAY});
    wait_b();
    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'b0101;
    send_aw(4'd4, 32'h200, 4'd0, 3'd2, 2'b01);
    send_w(0, -1);
    exp_b_q.push_back('{4'd4, OKAY});
    wait_b();
    exp_r_q.push_back('{32'hAA22_CC44, OKAY, 1'b1, 4'd8, 0});
    send_ar(4'd8, 32'h200, 4'd0, 3'd2, 2'b01, hs);
    wait_r(1);
    while (exp_b_q.size() > 0) begin
      bbeat_t e, g;
      e = exp_b_q.pop_front();
      checks++;
      g = got_b_q.size() > 0 ? got_b_q.pop_front() : '{4'hx, 2'bxx};
      if (g.id !== e.id || g.resp !== e.resp) begin
        failures++;
        $display("FAIL strobe_bresp: got id=%0d resp=%b, required id=%0d resp=%b", g.id, g.resp, e.id, e.resp);
      end
    end
    while (exp_r_q.size() > 0) begin
      rbeat_t e, g;
      e = exp_r_q.pop_front();
      checks++;
      g = got_r_q.size() > 0 ? got_r_q.pop_front() : '{32'hx, 2'bxx, 1'bx, 4'hx, 0};
      if (g.data !== e.data || g.resp !== e.resp || g.last !== e.last || g.id !== e.id) begin
        failures++;
        $display("FAIL strobe_read: got data=%h resp=%b last=%b id=%0d, required data=%h resp=%b last=%b id=%0d",
                 g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id);
      end
    end
  endtask

  task automatic test_out_of_range();
    int hs;
    exp_r_q.push_back('{32'd0, DECERR, 1'b0, 4'd3, 0});
    exp_r_q.push_back('{32'd0, DECERR, 1'b1, 4'd3, 0});
    send_ar(4'd3, 32'h0001_0000, 4'd1, 3'd2, 2'b01, hs);
    wait_r(2);
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'hF;
    send_aw(4'd6, 32'h0001_0000, 4'd0, 3'd2, 2'b01);
    send_w(0, -1);
    exp_b_q.push_back('{4'd6, DECERR});
    wait_b();
    exp_r_q.push_back('{32'hA000_0000, OKAY, 1'b1, 4'd3, 0});
    send_ar(4'd3, 32'h0, 4'd0, 3'd2, 2'b01, hs);
    wait_r(3);
    for (int i = 0; exp_r_q.size() > 0; i++) begin
      rbeat_t e, g;
      e = exp_r_q.pop_front();
      checks++;
      g = got_r_q.size() > 0 ? got_r_q.pop_front() : '{32'hx, 2'bxx, 1'bx, 4'hx, 0};
      if (g.data !== e.data || g.resp !== e.resp || g.last !== e.last || g.id !== e.id) begin
        failures++;
        $display("FAIL oor_read beat%0d: got data=%h resp=%b last=%b id=%0d, required data=%h resp=%b last=%b id=%0d",
                 i, g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id);
      end
    end
    while (exp_b_q.size() > 0) begin
      bbeat_t e, g;
      e = exp_b_q.pop_front();
      checks++;
      g = got_b_q.size() > 0 ? got_b_q.pop_front() : '{4'hx, 2'bxx};
      if (g.id !== e.id || g.resp !== e.resp) begin
        failures++;
        $display("FAIL oor_bresp: got id=%0d resp=%b, required id=%0d resp=%b", g.id, g.resp, e.id, e.resp);
      end
    end
  endtask

  task automatic test_backpressure();
    int hs;
    logic [7:0]  pat = 8'b1001_1001;
    logic        have_snap = 0;
    logic [31:0] snap_data = 0;
    logic        snap_last = 0;
    for (int i = 0; i < 4; i++) exp_r_q.push_back('{32'h11 * (i + 1), OKAY, i == 3, 4'd1, 0});
    s_axi_rready = 1;
    send_ar(4'd1, 32'h100, 4'd3, 3'd2, 2'b01, hs);
    for (int i = 0; i < 8; i++) begin
      s_axi_rready = pat[i];
      @(negedge aclk);
      if (!s_axi_rready) begin
        if (have_snap) begin
          checks++;
          if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== snap_data || s_axi_rlast !== snap_last) begin
            failures++;
            $display("FAIL stall_stable cycle%0d: got rvalid=%b rdata=%h rlast=%b, required rvalid=1 rdata=%h rlast=%b",
                     i, s_axi_rvalid, s_axi_rdata, s_axi_rlast, snap_data, snap_last);
          end
        end else begin
          have_snap = 1; snap_data = s_axi_rdata; snap_last = s_axi_rlast;
        end
      end else begin
        have_snap = 0;
      end
      @(posedge aclk); #1;
    end
    s_axi_rready = 1;
    wait_r(4);
    for (int i = 0; exp_r_q.size() > 0; i++) begin
      rbeat_t e, g;
      e = exp_r_q.pop_front();
      checks++;
      g = got_r_q.size() > 0 ? got_r_q.pop_front() : '{32'hx, 2'bxx, 1'bx, 4'hx, 0};
      if (g.data !== e.data || g.resp !== e.resp || g.last !== e.last || g.id !== e.id) begin
        failures++;
        $display("FAIL bp_read beat%0d: got data=%h resp=%b last=%b id=%0d, required data=%h resp=%b last=%b id=%0d",
                 i, g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id);
      end
    end
  endtask

  task automatic test_wlast_early();
    int hs;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h51 + i; sbuf[i] = 4'hF; end
    send_aw(4'd9, 32'h400, 4'd3, 3'd2, 2'b01);
    send_w(3, 1);
    exp_b_q.push_back('{4'd9, SLVERR});
    wait_b();
    for (int i = 0; i < 4; i++) exp_r_q.push_back('{32'h51 + i, OKAY, i == 3, 4'd10, 0});
    send_ar(4'd10, 32'h400, 4'd3, 3'd2, 2'b01, hs);
    wait_r(4);
    while (exp_b_q.size() > 0) begin
      bbeat_t e, g;
      e = exp_b_q.pop_front();
      checks++;
      g = got_b_q.size() > 0 ? got_b_q.pop_front() : '{4'hx, 2'bxx};
      if (g.id !== e.id || g.resp !== e.resp) begin
        failures++;
        $display("FAIL wlast_bresp: got id=%0d resp=%b, required id=%0d resp=%b", g.id, g.resp, e.id, e.resp);
      end
    end
    for (int i = 0; exp_r_q.size() > 0; i++) begin
      rbeat_t e, g;
      e = exp_r_q.pop_front();
      checks++;
      g = got_r_q.size() > 0 ? got_r_q.pop_front() : '{32'hx, 2'bxx, 1'bx, 4'hx, 0};
      if (g.data !== e.data || g.resp !== e.resp || g.last !== e.last || g.id !== e.id) begin
        failures++;
        $display("FAIL wlast_read beat%0d: got data=%h resp=%b last=%b id=%0d, required data=%h resp=%b last=%b id=%0d",
                 i, g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int hs;
    s_axi_rready = 0;
    send_ar(4'd4, 32'h100, 4'd3, 3'd2, 2'b01, hs);
    @(negedge aclk);
    checks++;
    if (s_axi_rvalid !== 1'b1) begin
      failures++; $display("FAIL midrd_active: rvalid=%b required=1", s_axi_rvalid);
    end
    aresetn = 0;
    #1;
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0) begin
      failures++;
      $display("FAIL midrd_abort: rvalid=%b rlast=%b required 0 0", s_axi_rvalid, s_axi_rlast);
    end
    @(posedge aclk); #1 aresetn = 1;
    s_axi_rready = 1;
    @(posedge aclk); #1;
    exp_r_q.push_back('{32'hAA22_CC44, OKAY, 1'b1, 4'd6, 0});
    send_ar(4'd6, 32'h200, 4'd0, 3'd2, 2'b01, hs);
    wait_r(1);
    repeat (2) @(posedge aclk);
    #1;
    while (exp_r_q.size() > 0) begin
      rbeat_t e, g;
      e = exp_r_q.pop_front();
      checks++;
      g = got_r_q.size() > 0 ? got_r_q.pop_front() : '{32'hx, 2'bxx, 1'bx, 4'hx, 0};
      if (g.data !== e.data || g.resp !== e.resp || g.last !== e.last || g.id !== e.id) begin
        failures++;
        $display("FAIL midrd_new_read: got data=%h resp=%b last=%b id=%0d, required data=%h resp=%b last=%b id=%0d",
                 g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id);
      end
    end
    checks++;
    if (got_r_q.size() != 0) begin
      failures++; $display("FAIL midrd_stale_beats: extra=%0d required=0", got_r_q.size());
    end
  endtask

  task automatic test_arbitration();
    int n = 0;
    int hs;
    apply_reset();
    s_axi_arid = 4'd1; s_axi_araddr = 32'h100; s_axi_arlen = 0; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
    s_axi_awid = 4'd2; s_axi_awaddr = 32'h500; s_axi_awlen = 0; s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
    s_axi_arvalid = 1; s_axi_awvalid = 1;
    exp_r_q.push_back('{32'h11, OKAY, 1'b1, 4'd1, 0});
    @(negedge aclk);
    checks++;
    if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b0) begin
      failures++;
      $display("FAIL arb_first: arready=%b awready=%b required 1 0", s_axi_arready, s_axi_awready);
    end
    @(posedge aclk); #1 s_axi_arvalid = 0;
    @(negedge aclk);
    while (!s_axi_awready && n < 100) begin @(negedge aclk); n++; end
    checks++;
    if (!s_axi_awready || got_r_q.size() != 1) begin
      failures++;
      $display("FAIL arb_second: awready=%b read_beats_before=%0d required 1 1", s_axi_awready, got_r_q.size());
    end
    @(posedge aclk); #1 s_axi_awvalid = 0;
    wbuf[0] = 32'h0000_0077; sbuf[0] = 4'hF;
    send_w(0, -1);
    exp_b_q.push_back('{4'd2, OKAY});
    wait_b();
    exp_r_q.push_back('{32'h77, OKAY, 1'b1, 4'd3, 0});
    send_ar(4'd3, 32'h500, 4'd0, 3'd2, 2'b01, hs);
    wait_r(2);
    for (int i = 0; exp_r_q.size() > 0; i++) begin
      rbeat_t e, g;
      e = exp_r_q.pop_front();
      checks++;
      g = got_r_q.size() > 0 ? got_r_q.pop_front() : '{32'hx, 2'bxx, 1'bx, 4'hx, 0};
      if (g.data !== e.data || g.resp !== e.resp || g.last !== e.last || g.id !== e.id) begin
        failures++;
        $display("FAIL arb_read%0d: got data=%h resp=%b last=%b id=%0d, required data=%h resp=%b last=%b id=%0d",
                 i, g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id);
      end
    end
    while (exp_b_q.size() > 0) begin
      bbeat_t e, g;
      e = exp_b_q.pop_front();
      checks++;
      g = got_b_q.size() > 0 ? got_b_q.pop_front() : '{4'hx, 2'bxx};
      if (g.id !== e.id || g.resp !== e.resp) begin
        failures++;
        $display("FAIL arb_bresp: got id=%0d resp=%b, required id=%0d resp=%b", g.id, g.resp, e.id, e.resp);
      end
    end
  endtask

  initial begin
    aresetn = 0;
    default_inputs();
    test_reset();
    test_incr_write_read();
    test_wrap_read();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_wlast_early();
    test_reset_mid_read();
    test_arbitration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
